// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and digit constants for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic {IDLE, CONV} bcd_state_t;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction; digit_i in, digit_o = digit_i+3 when digit_i >= 5
module bcd_add3 import bcd_pkg::*; (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  assign digit_o = (digit_i >= BCD_ADD3_THRESH) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/bin16_to_bcd.sv
// bin16_to_bcd: sequential double-dabble; CLK100MHZ/reset/start/bin_in in, busy/done/bcd_out (registered) out
module bin16_to_bcd import bcd_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  bcd_state_t       state_q;
  logic [SR_W-1:0]  sr_q, sr_d, corr;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [BCD_W-1:0] bcd_q;
  assign corr[WIDTH-1:0] = sr_q[WIDTH-1:0];
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i(sr_q[WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .digit_o(corr[WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end
  assign sr_d    = {corr[SR_W-2:0], 1'b0};
  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          sr_q    <= {{BCD_W{1'b0}}, bin_in};
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CONV;
        end
      end else begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_q   <= sr_d[SR_W-1:WIDTH];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
endmodule
